soft_max_ctrl: RTL and testbench
================================

Name: soft_max_ctrl

Overview:
- Row sequencer for the softmax datapath (SOFT_MAX).
- For each row request it streams row chunks from a row buffer twice: first a denominator pass, then a numerator pass.
- It clears the accumulator between rows, waits for the denominator sum, and counts results so it can report row completion.
- It sits between the attention score buffer and SOFT_MAX.

Parameters:
- DATA_WIDTH, 16, element width (FP16).
- DATA_NUM, 4, elements per chunk.
- INFO_WIDTH, 20, info field width.
- ADDR_WIDTH, 10, row buffer address width.
- LEN_WIDTH, 8, chunk-count width.
- TIMEOUT, 255, maximum WAIT_SUM cycles before error.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- start  in  1  row request.
- start_rdy  out  1  controller idle; request accepted when start&start_rdy.
- row_base  in  ADDR_WIDTH  first chunk address.
- row_len  in  LEN_WIDTH  number of chunks; 0 is illegal.
- row_tag  in  INFO_WIDTH-16  row identifier.
- rd_en  out  1  row buffer read.
- rd_addr  out  ADDR_WIDTH  read address.
- rd_data  in  DATA_NUM*DATA_WIDTH  read data, valid the cycle after rd_en.
- sum_clear  out  1  accumulator clear pulse.
- denomintor_in_vld  out  1  denominator chunk valid.
- numerator_in_vld  out  1  numerator chunk valid.
- denomintor_in  out  DATA_NUM*DATA_WIDTH  chunk data.
- numerator_in  out  DATA_NUM*DATA_WIDTH  chunk data.
- soft_max_info_in  out  INFO_WIDTH  chunk info.
- denomintor_sum_ok  in  1  denominator sum complete.
- out_vld  in  1  SOFT_MAX result valid.
- row_done  out  1  one-cycle completion pulse.
- err  out  1  sticky timeout / illegal-length flag.

Behaviour:
- Reset: synchronous active-high. Asserting rst in any state returns to IDLE. At reset:
  - all pulses/valids = 0, err = 0, counters = 0, start_rdy = 1.
  - In-flight SOFT_MAX results arriving after reset are ignored.
- Info field:
  - [INFO_WIDTH-1:16] = row_tag.
  - [15] = last-chunk flag.
  - [14:0] = chunk index, zero-extended.
- States: IDLE, CLEAR, DEN, WAIT_SUM, NUM, DRAIN.
- IDLE:
  - start_rdy = 1.
  - On start: latch row_base, row_len, row_tag, then go to CLEAR.
  - If start with row_len == 0: set err, no other effect, stay in IDLE.
- CLEAR: sum_clear = 1 for exactly one cycle, then go to DEN.
- DEN:
  - rd_en = 1 for row_len consecutive cycles; rd_addr = row_base + k, k = 0..row_len-1. Address wraps modulo 2^ADDR_WIDTH.
  - One cycle after each read: denomintor_in_vld = 1, denomintor_in = rd_data, info chunk index = k, info[15] = (k == row_len-1).
  - Go to WAIT_SUM after the last chunk is issued.
- WAIT_SUM:
  - No issue.
  - On denomintor_sum_ok go to NUM.
  - If TIMEOUT cycles elapse without it: set err and return to IDLE. No row_done.
- NUM:
  - Same address/issue sequence as DEN, driving numerator_in_vld / numerator_in.
  - info[15] = 0 on all chunks.
- DRAIN:
  - Count out_vld pulses; counting runs from entry to NUM, so results arriving during NUM are counted.
  - When the count reaches row_len: row_done = 1 for one cycle, then go to IDLE.
  - out_vld in IDLE / CLEAR / DEN / WAIT_SUM is ignored.
- Exclusivity:
  - denomintor_in_vld and numerator_in_vld are never high together.
  - Data buses are held at 0 when their valid is low.
- Throughput: one chunk per cycle; a new row can start the cycle after row_done.
- err clears only on rst.

Decomposition:
- Shared package soft_max_pkg:
  - state encoding.
  - info bit positions: INFO_LAST_BIT = 15, INFO_IDX_MSB = 14, INFO_TAG_LSB = 16.
- One natural sub-module: soft_max_chunk_issuer.
  - Address counter, 1-cycle read-valid pipeline, last-flag generation.
  - Instantiated once and reused for both passes, selected by a pass bit.

Test Plan:
- Basic row: start, row_base = 0x010, row_len = 3; BFM asserts denomintor_sum_ok 6 cycles after last DEN chunk and returns 3 out_vld.
  -> rd_addr 0x010..0x012 twice.
  -> sum_clear once, before first DEN valid.
  -> info[15] = 1 only on DEN chunk 2.
  -> row_done exactly once.
- row_len = 1 -> one DEN chunk with info = {tag, 1, 0}; one NUM chunk with info[15] = 0.
- Timeout: denomintor_sum_ok never asserted -> err = 1 at TIMEOUT+1 cycles into WAIT_SUM; start_rdy = 1; no NUM valid.
- Wrap: row_base = 0x3FE, row_len = 4 -> rd_addr 0x3FE, 0x3FF, 0x000, 0x001.
- Reset mid-NUM: rst after 2 of 4 NUM chunks, then 2 late out_vld.
  -> no further valids.
  -> no row_done.
  -> next row (row_len = 2) completes normally.
- Illegal start: row_len = 0 -> err = 1; no rd_en or sum_clear.

Source files
------------

// File: rtl/soft_max_pkg.sv
// soft_max_pkg
//   Shared definitions for the softmax row sequencer:
//   - controller state encoding
//   - pass selector (denominator / numerator)
//   - info field bit positions and a helper that packs the low info bits
package soft_max_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CLEAR,
      ST_DEN,
      ST_WAIT_SUM,
      ST_NUM,
      ST_DRAIN
   } state_t;

   typedef enum logic {
      PASS_DEN = 1'b0,
      PASS_NUM = 1'b1
   } pass_t;

   localparam int unsigned INFO_LAST_BIT = 15;
   localparam int unsigned INFO_IDX_MSB  = 14;
   localparam int unsigned INFO_TAG_LSB  = 16;

   // Low part of the info word: {last-chunk flag, chunk index}
   function automatic logic [INFO_TAG_LSB-1:0] info_low(
      input logic                  last,
      input logic [INFO_IDX_MSB:0] idx
   );
      return {last, idx};
   endfunction

endpackage

// File: rtl/soft_max_chunk_issuer.sv
// soft_max_chunk_issuer
//   Walks row_len consecutive row-buffer addresses while i_en is high and
//   presents each returned chunk one cycle later on the denominator or
//   numerator bus, as selected by the pass bit. Shared by both passes.
//
// Ports
//   clk, rst        clock, synchronous active-high reset
//   i_en            issue one read per cycle while high; index restarts at 0
//                   whenever it is low
//   i_pass          pass of the reads being issued (den / num)
//   i_base, i_len   first address and chunk count of the row
//   i_tag           row identifier placed in the info field
//   i_rd_data       row buffer data, valid the cycle after a read
//   o_rd_en/addr    row buffer read strobe and address (wraps)
//   o_at_last       current index is the last chunk of the row
//   o_busy          a chunk is being presented this cycle
//   o_den_*/o_num_* chunk valids and data (data is 0 while valid is low)
//   o_info          {tag, last, index} of the presented chunk, 0 when idle
module soft_max_chunk_issuer
   import soft_max_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 16,
   parameter int unsigned DATA_NUM   = 4,
   parameter int unsigned INFO_WIDTH = 20,
   parameter int unsigned ADDR_WIDTH = 10,
   parameter int unsigned LEN_WIDTH  = 8
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             i_en,
   input  pass_t                            i_pass,
   input  logic [ADDR_WIDTH-1:0]            i_base,
   input  logic [LEN_WIDTH-1:0]             i_len,
   input  logic [INFO_WIDTH-INFO_TAG_LSB-1:0] i_tag,
   input  logic [DATA_NUM*DATA_WIDTH-1:0]   i_rd_data,
   output logic                             o_rd_en,
   output logic [ADDR_WIDTH-1:0]            o_rd_addr,
   output logic                             o_at_last,
   output logic                             o_busy,
   output logic                             o_den_vld,
   output logic                             o_num_vld,
   output logic [DATA_NUM*DATA_WIDTH-1:0]   o_den_data,
   output logic [DATA_NUM*DATA_WIDTH-1:0]   o_num_data,
   output logic [INFO_WIDTH-1:0]            o_info
);

   localparam int unsigned IDX_W = INFO_IDX_MSB + 1;

   logic [LEN_WIDTH-1:0] r_k;
   logic [LEN_WIDTH-1:0] r_idx;
   logic                 r_vld;
   logic                 r_last;
   pass_t                r_pass;

   logic                 w_at_last;

   assign w_at_last = (r_k == (i_len - LEN_WIDTH'(1)));
   assign o_at_last = w_at_last;
   assign o_rd_en   = i_en;
   assign o_rd_addr = i_base + ADDR_WIDTH'(r_k);
   assign o_busy    = r_vld;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_k    <= '0;
         r_idx  <= '0;
         r_vld  <= 1'b0;
         r_last <= 1'b0;
         r_pass <= PASS_DEN;
      end else begin
         r_vld  <= i_en;
         r_pass <= i_pass;
         r_idx  <= r_k;
         // only the denominator pass marks its final chunk
         r_last <= i_en & w_at_last & (i_pass == PASS_DEN);
         if (i_en) begin
            r_k <= r_k + LEN_WIDTH'(1);
         end else begin
            r_k <= '0;
         end
      end
   end

   always_comb begin
      o_den_vld  = r_vld & (r_pass == PASS_DEN);
      o_num_vld  = r_vld & (r_pass == PASS_NUM);
      o_den_data = o_den_vld ? i_rd_data : '0;
      o_num_data = o_num_vld ? i_rd_data : '0;
      o_info     = r_vld ? {i_tag, info_low(r_last, IDX_W'(r_idx))} : '0;
   end

endmodule

// File: rtl/soft_max_ctrl.sv
// soft_max_ctrl
//   Row sequencer for the softmax datapath. Per accepted row request it
//   clears the accumulator, streams the row once as denominator chunks,
//   waits for the denominator sum, streams it again as numerator chunks and
//   counts SOFT_MAX results until the whole row has come back.
//
// Ports
//   clk, rst              clock, synchronous active-high reset
//   start / start_rdy     row request handshake (accepted on start&start_rdy)
//   row_base/len/tag      first chunk address, chunk count (0 illegal), row id
//   rd_en/rd_addr/rd_data row buffer read port (data one cycle after rd_en)
//   sum_clear             one-cycle accumulator clear
//   denomintor_in_vld/_in denominator pass chunk stream
//   numerator_in_vld/_in  numerator pass chunk stream
//   soft_max_info_in      {row_tag, last-chunk flag, chunk index}
//   denomintor_sum_ok     denominator sum is ready
//   out_vld               one SOFT_MAX result returned
//   row_done              one-cycle row completion pulse
//   err                   sticky: sum timeout or zero-length request
module soft_max_ctrl
   import soft_max_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 16,
   parameter int unsigned DATA_NUM   = 4,
   parameter int unsigned INFO_WIDTH = 20,
   parameter int unsigned ADDR_WIDTH = 10,
   parameter int unsigned LEN_WIDTH  = 8,
   parameter int unsigned TIMEOUT    = 255
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           start,
   output logic                           start_rdy,
   input  logic [ADDR_WIDTH-1:0]          row_base,
   input  logic [LEN_WIDTH-1:0]           row_len,
   input  logic [INFO_WIDTH-17:0]         row_tag,
   output logic                           rd_en,
   output logic [ADDR_WIDTH-1:0]          rd_addr,
   input  logic [DATA_NUM*DATA_WIDTH-1:0] rd_data,
   output logic                           sum_clear,
   output logic                           denomintor_in_vld,
   output logic                           numerator_in_vld,
   output logic [DATA_NUM*DATA_WIDTH-1:0] denomintor_in,
   output logic [DATA_NUM*DATA_WIDTH-1:0] numerator_in,
   output logic [INFO_WIDTH-1:0]          soft_max_info_in,
   input  logic                           denomintor_sum_ok,
   input  logic                           out_vld,
   output logic                           row_done,
   output logic                           err
);

   localparam int unsigned WAIT_W = $clog2(TIMEOUT + 1);

   state_t                  r_state;
   state_t                  w_next;
   logic [ADDR_WIDTH-1:0]   r_base;
   logic [LEN_WIDTH-1:0]    r_len;
   logic [INFO_WIDTH-17:0]  r_tag;
   logic                    r_err;
   logic [WAIT_W-1:0]       r_wait;
   logic [LEN_WIDTH-1:0]    r_res_cnt;

   logic                    w_issue_en;
   pass_t                   w_pass;
   logic                    w_at_last;
   logic                    w_busy;
   logic                    w_wait_expired;

   // Issue enable derived from the state register only, so the next-state
   // logic can consume the issuer's last-index flag without a feedback path.
   assign w_issue_en     = (r_state == ST_DEN) || (r_state == ST_NUM);
   assign w_pass         = (r_state == ST_NUM) ? PASS_NUM : PASS_DEN;
   assign w_wait_expired = (r_wait == WAIT_W'(TIMEOUT - 1));
   assign err            = r_err;

   soft_max_chunk_issuer #(
      .DATA_WIDTH (DATA_WIDTH),
      .DATA_NUM   (DATA_NUM),
      .INFO_WIDTH (INFO_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH),
      .LEN_WIDTH  (LEN_WIDTH)
   ) u_issuer (
      .clk        (clk),
      .rst        (rst),
      .i_en       (w_issue_en),
      .i_pass     (w_pass),
      .i_base     (r_base),
      .i_len      (r_len),
      .i_tag      (r_tag),
      .i_rd_data  (rd_data),
      .o_rd_en    (rd_en),
      .o_rd_addr  (rd_addr),
      .o_at_last  (w_at_last),
      .o_busy     (w_busy),
      .o_den_vld  (denomintor_in_vld),
      .o_num_vld  (numerator_in_vld),
      .o_den_data (denomintor_in),
      .o_num_data (numerator_in),
      .o_info     (soft_max_info_in)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= ST_IDLE;
         r_base    <= '0;
         r_len     <= '0;
         r_tag     <= '0;
         r_err     <= 1'b0;
         r_wait    <= '0;
         r_res_cnt <= '0;
      end else begin
         r_state <= w_next;

         if ((r_state == ST_IDLE) && start) begin
            if (row_len == '0) begin
               r_err <= 1'b1;
            end else begin
               r_base <= row_base;
               r_len  <= row_len;
               r_tag  <= row_tag;
            end
         end

         if ((r_state == ST_WAIT_SUM) && !denomintor_sum_ok && w_wait_expired) begin
            r_err <= 1'b1;
         end

         if (r_state == ST_WAIT_SUM) begin
            r_wait <= r_wait + WAIT_W'(1);
         end else begin
            r_wait <= '0;
         end

         // NUM is only entered from WAIT_SUM, so clearing there starts the
         // result count exactly at NUM entry; earlier out_vld is ignored.
         if (r_state == ST_WAIT_SUM) begin
            r_res_cnt <= '0;
         end else if (((r_state == ST_NUM) || (r_state == ST_DRAIN)) && out_vld
                      && (r_res_cnt != r_len)) begin
            r_res_cnt <= r_res_cnt + LEN_WIDTH'(1);
         end
      end
   end

   always_comb begin
      w_next    = r_state;
      start_rdy = 1'b0;
      sum_clear = 1'b0;
      row_done  = 1'b0;
      case (r_state)
         ST_IDLE: begin
            start_rdy = 1'b1;
            if (start && (row_len != '0)) begin
               w_next = ST_CLEAR;
            end
         end
         ST_CLEAR: begin
            sum_clear = 1'b1;
            w_next    = ST_DEN;
         end
         ST_DEN: begin
            if (w_at_last) begin
               w_next = ST_WAIT_SUM;
            end
         end
         ST_WAIT_SUM: begin
            if (denomintor_sum_ok) begin
               w_next = ST_NUM;
            end else if (w_wait_expired) begin
               w_next = ST_IDLE;
            end
         end
         ST_NUM: begin
            if (w_at_last) begin
               w_next = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            // also wait for the final numerator chunk to leave the issuer
            if ((r_res_cnt == r_len) && !w_busy) begin
               row_done = 1'b1;
               w_next   = ST_IDLE;
            end
         end
         default: begin
            w_next = ST_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_soft_max_ctrl.sv
module tb_soft_max_ctrl;

   localparam int DW = 16;
   localparam int DN = 4;
   localparam int IW = 20;
   localparam int AW = 10;
   localparam int LW = 8;
   localparam int TO = 255;
   localparam int BW = DW * DN;
   localparam int TW = IW - 16;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic          start_rdy;
   logic [AW-1:0] row_base;
   logic [LW-1:0] row_len;
   logic [TW-1:0] row_tag;
   logic          rd_en;
   logic [AW-1:0] rd_addr;
   logic [BW-1:0] rd_data;
   logic          sum_clear;
   logic          denomintor_in_vld;
   logic          numerator_in_vld;
   logic [BW-1:0] denomintor_in;
   logic [BW-1:0] numerator_in;
   logic [IW-1:0] soft_max_info_in;
   logic          denomintor_sum_ok;
   logic          out_vld;
   logic          row_done;
   logic          err;

   always #5 clk = ~clk;

   soft_max_ctrl #(
      .DATA_WIDTH (DW),
      .DATA_NUM   (DN),
      .INFO_WIDTH (IW),
      .ADDR_WIDTH (AW),
      .LEN_WIDTH  (LW),
      .TIMEOUT    (TO)
   ) dut (
      .clk               (clk),
      .rst               (rst),
      .start             (start),
      .start_rdy         (start_rdy),
      .row_base          (row_base),
      .row_len           (row_len),
      .row_tag           (row_tag),
      .rd_en             (rd_en),
      .rd_addr           (rd_addr),
      .rd_data           (rd_data),
      .sum_clear         (sum_clear),
      .denomintor_in_vld (denomintor_in_vld),
      .numerator_in_vld  (numerator_in_vld),
      .denomintor_in     (denomintor_in),
      .numerator_in      (numerator_in),
      .soft_max_info_in  (soft_max_info_in),
      .denomintor_sum_ok (denomintor_sum_ok),
      .out_vld           (out_vld),
      .row_done          (row_done),
      .err               (err)
   );

   typedef struct {
      logic [BW-1:0] data;
      logic [IW-1:0] info;
   } chunk_t;

   logic [BW-1:0] mem [1<<AW];

   chunk_t        exp_den  [$];
   chunk_t        exp_num  [$];
   logic [AW-1:0] exp_addr [$];
   logic [TW-1:0] exp_done [$];

   int     n_chk  = 0;
   int     n_fail = 0;
   longint cyc    = 0;

   // monitor-owned observation counters
   int     n_clear = 0;
   int     n_done  = 0;
   int     n_num   = 0;
   int     n_rd    = 0;
   longint last_den_cyc = 0;

   // stimulus-owned BFM controls
   int     sum_delay = 0;
   bit     auto_out  = 1'b1;
   int     inj_req   = 0;

   function automatic void chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endfunction

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // Row buffer, sum-ready and SOFT_MAX result model
   initial begin : bfm
      bit            s_rd;
      logic [AW-1:0] s_addr;
      int            cd;
      int            pend;
      int            inj_done;
      cd = -1; pend = 0; inj_done = 0;
      rd_data = '0; denomintor_sum_ok = 1'b0; out_vld = 1'b0;
      forever begin
         @(negedge clk);
         s_rd   = rd_en;
         s_addr = rd_addr;
         if (rst) begin
            pend = 0;
            cd   = -1;
         end else begin
            if (numerator_in_vld && auto_out) pend++;
            if (denomintor_in_vld && soft_max_info_in[15] && sum_delay >= 0) cd = sum_delay;
         end
         @(posedge clk);
         #1;
         rd_data = s_rd ? mem[s_addr] : {$urandom, $urandom};
         denomintor_sum_ok = 1'b0;
         if (cd == 0) begin
            denomintor_sum_ok = 1'b1;
            cd = -1;
         end else if (cd > 0) begin
            cd--;
         end
         out_vld = 1'b0;
         if (inj_done < inj_req) begin
            out_vld = 1'b1;
            inj_done++;
         end else if (pend > 0 && $urandom_range(0, 2) != 0) begin
            out_vld = 1'b1;
            pend--;
         end
      end
   end

   // Monitor / scoreboard
   initial begin : monitor
      bit     clr_armed;
      chunk_t c;
      clr_armed = 1'b0;
      forever begin
         @(negedge clk);
         chk("valid_exclusive", denomintor_in_vld && numerator_in_vld, 0);
         if (rd_en) begin
            n_rd++;
            chk("rd_expected", exp_addr.size() > 0, 1);
            if (exp_addr.size() > 0) chk("rd_addr", rd_addr, exp_addr.pop_front());
         end
         if (!denomintor_in_vld) chk("den_bus_zero", denomintor_in, 0);
         if (!numerator_in_vld)  chk("num_bus_zero", numerator_in, 0);
         if (denomintor_in_vld) begin
            chk("den_expected", exp_den.size() > 0, 1);
            if (exp_den.size() > 0) begin
               c = exp_den.pop_front();
               chk("den_data", denomintor_in, c.data);
               chk("den_info", soft_max_info_in, c.info);
               if (c.info[14:0] == 15'd0) begin
                  chk("clear_before_den", clr_armed, 1);
                  clr_armed = 1'b0;
               end
            end
            if (soft_max_info_in[15]) last_den_cyc = cyc;
         end
         if (numerator_in_vld) begin
            n_num++;
            chk("num_expected", exp_num.size() > 0, 1);
            if (exp_num.size() > 0) begin
               c = exp_num.pop_front();
               chk("num_data", numerator_in, c.data);
               chk("num_info", soft_max_info_in, c.info);
            end
         end
         if (sum_clear) begin
            n_clear++;
            clr_armed = 1'b1;
         end
         if (row_done) begin
            n_done++;
            chk("row_done_expected", exp_done.size() > 0, 1);
            if (exp_done.size() > 0) void'(exp_done.pop_front());
         end
      end
   end

   task automatic push_pass(input logic [AW-1:0] base, input int len, input logic [TW-1:0] tag,
                            input bit den, input int n_vld);
      logic [AW-1:0] a;
      chunk_t        c;
      for (int k = 0; k < len; k++) begin
         a = base + AW'(k);
         exp_addr.push_back(a);
         if (k < n_vld) begin
            c.data = mem[a];
            c.info = {tag, (den && k == len - 1), 15'(k)};
            if (den) exp_den.push_back(c);
            else     exp_num.push_back(c);
         end
      end
   endtask

   task automatic issue_start(input logic [AW-1:0] base, input logic [LW-1:0] len, input logic [TW-1:0] tag);
      bit rdy;
      rdy = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (start_rdy) begin
            rdy = 1'b1;
            break;
         end
      end
      chk("start_rdy_wait", rdy, 1);
      start = 1'b1; row_base = base; row_len = len; row_tag = tag;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic queues_empty(input string tag);
      chk({tag, "_den_left"},  exp_den.size(),  0);
      chk({tag, "_num_left"},  exp_num.size(),  0);
      chk({tag, "_addr_left"}, exp_addr.size(), 0);
      chk({tag, "_done_left"}, exp_done.size(), 0);
      exp_den.delete(); exp_num.delete(); exp_addr.delete(); exp_done.delete();
   endtask

   task automatic run_row(input logic [AW-1:0] base, input int len, input logic [TW-1:0] tag, input int delay);
      int clr0;
      int done0;
      bit got;
      clr0 = n_clear; done0 = n_done; got = 1'b0;
      sum_delay = delay; auto_out = 1'b1;
      push_pass(base, len, tag, 1'b1, len);
      push_pass(base, len, tag, 1'b0, len);
      exp_done.push_back(tag);
      issue_start(base, LW'(len), tag);
      for (int i = 0; i < 2000; i++) begin
         @(negedge clk);
         if (row_done) begin
            got = 1'b1;
            break;
         end
      end
      chk("row_done_seen", got, 1);
      @(negedge clk);
      chk("start_rdy_after_done", start_rdy, 1);
      chk("sum_clear_once", n_clear - clr0, 1);
      chk("row_done_once", n_done - done0, 1);
      queues_empty("row");
   endtask

   initial begin : stim
      int   clr0;
      int   num0;
      int   done0;
      int   rd0;
      int   seen;
      bit   got;
      longint err_cyc;
      logic [AW-1:0] b;

      for (int i = 0; i < (1 << AW); i++) mem[i] = {$urandom, $urandom};
      rst = 1'b1; start = 1'b0; row_base = '0; row_len = '0; row_tag = '0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      chk("rst_start_rdy", start_rdy, 1);
      chk("rst_err", err, 0);
      chk("rst_rd_en", rd_en, 0);
      chk("rst_sum_clear", sum_clear, 0);
      chk("rst_row_done", row_done, 0);
      chk("rst_den_vld", denomintor_in_vld, 0);
      chk("rst_num_vld", numerator_in_vld, 0);

      // basic row, single-chunk row, address wrap
      run_row(10'h010, 3, 4'hA, 5);
      run_row(AW'($urandom), 1, 4'h3, 2);
      run_row(10'h3FE, 4, 4'h5, 0);

      for (int r = 0; r < 6; r++) begin
         run_row(AW'($urandom), $urandom_range(1, 12), TW'($urandom), $urandom_range(0, 8));
      end

      // reset in the middle of the numerator pass
      b = AW'($urandom);
      auto_out = 1'b0; sum_delay = 1;
      push_pass(b, 4, 4'h9, 1'b1, 4);
      push_pass(b, 3, 4'h9, 1'b0, 2);
      done0 = n_done; num0 = n_num; seen = 0; got = 1'b0;
      issue_start(b, 8'd4, 4'h9);
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (numerator_in_vld) seen++;
         if (seen == 2) begin
            got = 1'b1;
            rst = 1'b1;
            break;
         end
      end
      chk("rst_mid_num_reached", got, 1);
      @(negedge clk);
      rst = 1'b0;
      inj_req = inj_req + 2;
      repeat (10) @(negedge clk);
      chk("rst_mid_no_done", n_done - done0, 0);
      chk("rst_mid_num_count", n_num - num0, 2);
      chk("rst_mid_start_rdy", start_rdy, 1);
      queues_empty("rst_mid");
      run_row(b + AW'(7), 2, 4'h6, 3);

      // denominator sum never arrives
      b = AW'($urandom);
      clr0 = n_clear; num0 = n_num; got = 1'b0; err_cyc = 0;
      sum_delay = -1; auto_out = 1'b1;
      push_pass(b, 3, 4'hC, 1'b1, 3);
      issue_start(b, 8'd3, 4'hC);
      for (int i = 0; i < 700; i++) begin
         @(negedge clk);
         if (err) begin
            got = 1'b1;
            err_cyc = cyc;
            break;
         end
      end
      chk("timeout_err_set", got, 1);
      chk("timeout_latency", 128'(err_cyc - last_den_cyc), TO);
      chk("timeout_start_rdy", start_rdy, 1);
      repeat (5) @(negedge clk);
      chk("timeout_no_num", n_num - num0, 0);
      chk("timeout_clear_once", n_clear - clr0, 1);
      chk("timeout_err_sticky", err, 1);
      queues_empty("timeout");

      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("rst_clears_err", err, 0);
      chk("rst2_start_rdy", start_rdy, 1);

      // zero-length request
      clr0 = n_clear; rd0 = n_rd;
      issue_start(AW'($urandom), 8'd0, 4'h1);
      repeat (6) @(negedge clk);
      chk("illegal_err", err, 1);
      chk("illegal_start_rdy", start_rdy, 1);
      chk("illegal_no_clear", n_clear - clr0, 0);
      chk("illegal_no_read", n_rd - rd0, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
